// File: rtl/nibble_word_packer.sv
// nibble_word_packer
// Drains nibbles from a 4-bit synchronous FIFO with a registered read port and
// packs them little-endian into NIB_W*NIBS-bit words on a valid/ready port.
// A flush pushes out any partial word, with out_keep marking the valid nibbles.
module nibble_word_packer #(
  parameter int NIB_W = 4,
  parameter int NIBS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [NIB_W-1:0]      fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [NIB_W*NIBS-1:0] out_data,
  output logic [NIBS-1:0]       out_keep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int WORD_W = NIB_W * NIBS;
  localparam int CNT_W  = $clog2(NIBS + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NIBS);

  // Registered state
  logic [WORD_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              pend_r;
  logic              flush_req_r;
  logic [WORD_W-1:0] out_data_r;
  logic [NIBS-1:0]   out_keep_r;
  logic              out_valid_r;
  logic              busy_r;

  // Combinational decisions and next-state values
  logic              slot_free_s;
  logic              full_xfer_s;
  logic              part_xfer_s;
  logic [CNT_W:0]    fill_s;
  logic              rd_en_s;
  logic [NIBS-1:0]   part_keep_s;
  logic [WORD_W-1:0] acc_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              pend_nxt_s;
  logic              flush_req_nxt_s;
  logic [WORD_W-1:0] out_data_nxt_s;
  logic [NIBS-1:0]   out_keep_nxt_s;
  logic              out_valid_nxt_s;
  logic              busy_nxt_s;

  // Transfer conditions and the FIFO read request.
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
    full_xfer_s = (cnt_r == CNT_FULL) && slot_free_s;
    part_xfer_s = flush_req_r && !pend_r && (cnt_r != CNT_ZERO) &&
                  (cnt_r < CNT_FULL) && slot_free_s;
    // Nibbles held plus the one in flight; a read is allowed while this is
    // below a full word, or when the full word leaves on this same edge.
    fill_s      = {1'b0, cnt_r} + {{CNT_W{1'b0}}, pend_r};
    rd_en_s     = !rst && !fifo_empty && !flush_req_r &&
                  ((fill_s < {1'b0, CNT_FULL}) || full_xfer_s);
  end

  assign fifo_rd_en = rd_en_s;

  // Keep mask for a partial word: the low cnt nibbles are valid.
  always_comb begin
    part_keep_s = {NIBS{1'b0}};
    for (int i = 0; i < NIBS; i++) begin
      part_keep_s[i] = (CNT_W'(i) < cnt_r);
    end
  end

  // Next-state: capture, word transfer, flush tracking and output handshake.
  always_comb begin
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    pend_nxt_s      = rd_en_s;
    flush_req_nxt_s = flush_req_r;
    out_data_nxt_s  = out_data_r;
    out_keep_nxt_s  = out_keep_r;
    out_valid_nxt_s = out_valid_r && !out_ready;

    // The nibble read last cycle lands in slot cnt.
    if (pend_r) begin
      for (int i = 0; i < NIBS; i++) begin
        acc_nxt_s[i*NIB_W +: NIB_W] = (CNT_W'(i) == cnt_r) ? fifo_data
                                                           : acc_r[i*NIB_W +: NIB_W];
      end
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    // A transfer never coincides with a capture, so it may overwrite acc/cnt.
    if (full_xfer_s) begin
      out_data_nxt_s  = acc_r;
      out_keep_nxt_s  = {NIBS{1'b1}};
      out_valid_nxt_s = 1'b1;
      acc_nxt_s       = {WORD_W{1'b0}};
      cnt_nxt_s       = CNT_ZERO;
    end else if (part_xfer_s) begin
      // Unfilled nibbles of acc are already zero since acc clears per word.
      out_data_nxt_s  = acc_r;
      out_keep_nxt_s  = part_keep_s;
      out_valid_nxt_s = 1'b1;
      acc_nxt_s       = {WORD_W{1'b0}};
      cnt_nxt_s       = CNT_ZERO;
    end else begin
      out_data_nxt_s  = out_data_r;
      out_keep_nxt_s  = out_keep_r;
    end

    // A new flush request wins over completion of the previous one.
    if (flush) begin
      flush_req_nxt_s = 1'b1;
    end else if (flush_req_r &&
                 (((cnt_r == CNT_ZERO) && !pend_r) || part_xfer_s || full_xfer_s)) begin
      flush_req_nxt_s = 1'b0;
    end else begin
      flush_req_nxt_s = flush_req_r;
    end

    busy_nxt_s = (cnt_nxt_s != CNT_ZERO) || pend_nxt_s || out_valid_nxt_s ||
                 flush_req_nxt_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {WORD_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      pend_r      <= 1'b0;
      flush_req_r <= 1'b0;
      out_data_r  <= {WORD_W{1'b0}};
      out_keep_r  <= {NIBS{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pend_r      <= pend_nxt_s;
      flush_req_r <= flush_req_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_keep_r  <= out_keep_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_keep  = out_keep_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule
